// File: rtl/scrambler_pkg.sv
// -----------------------------------------------------------------------------
// scrambler_pkg
// Definitions shared by the transmit scrambler and the receive descrambler:
// FSM state encoding, LFSR width, tap positions, default seed, default length
// width, and the LFSR feedback function (polynomial x^7 + x^4 + 1).
// -----------------------------------------------------------------------------
package scrambler_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      INIT       = 2'd1,
      SCRAMBLING = 2'd2,
      FINISH     = 2'd3
   } state_t;

   localparam int              LFSR_W           = 7;
   localparam int              TAP_HI           = 6;
   localparam int              TAP_LO           = 3;
   localparam logic [LFSR_W-1:0] DEFAULT_SEED   = 7'h7F;
   localparam int              DEFAULT_LENGTH_W = 12;

   // Feedback bit of the additive scrambling sequence.
   function automatic logic lfsr_fb(input logic [LFSR_W-1:0] s);
      return s[TAP_HI] ^ s[TAP_LO];
   endfunction

endpackage

// File: rtl/scrambler_lfsr.sv
// -----------------------------------------------------------------------------
// scrambler_lfsr
// 7-bit Fibonacci LFSR (x^7 + x^4 + 1) with synchronous load and shift enable.
// Shared by the scrambler and the descrambler.
// Ports:
//   clk      clock
//   reset    synchronous active-high reset (state <= RESET_SEED)
//   load_i   load seed_i into the register (has priority over shift_i)
//   shift_i  advance the sequence by one step
//   seed_i   load value
//   state_o  current register contents
//   fb_o     feedback bit of the current state (the keystream bit)
// -----------------------------------------------------------------------------
module scrambler_lfsr
   import scrambler_pkg::*;
#(
   parameter logic [LFSR_W-1:0] RESET_SEED = DEFAULT_SEED
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic              shift_i,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [LFSR_W-1:0] state_o,
   output logic              fb_o
);

   logic [LFSR_W-1:0] state_q;
   logic [LFSR_W-1:0] state_d;

   assign fb_o    = lfsr_fb(state_q);
   assign state_o = state_q;

   always_comb begin
      state_d = state_q;
      if (load_i) begin
         state_d = seed_i;
      end else if (shift_i) begin
         state_d = {state_q[LFSR_W-2:0], fb_o};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RESET_SEED;
      end else begin
         state_q <= state_d;
      end
   end

endmodule

// File: rtl/scrambler_tx.sv
// -----------------------------------------------------------------------------
// scrambler_tx
// Transmit frame scrambler. Accepts a frame request with a bit length, pulls
// exactly that many serial bits from upstream and XORs each with an additive
// LFSR keystream reseeded at every frame start.
// Optional build macro: TX_RUNTIME_SEED_EN adds a run-time seed input.
// Ports:
//   clk       clock
//   reset     synchronous active-high reset
//   request   frame start request (sampled in IDLE only)
//   length    frame length in bits (captured with an accepted request)
//   data_req  data_in is consumed at the next rising edge
//   data_in   payload bit
//   data_out  scrambled bit (registered, holds while valid=0)
//   valid     data_out carries a scrambled bit
//   busy      frame in progress
//   done      one-cycle end-of-frame pulse
//   seed      (TX_RUNTIME_SEED_EN only) LFSR seed captured with the request
// -----------------------------------------------------------------------------
module scrambler_tx
   import scrambler_pkg::*;
#(
   parameter int                LENGTH_W = DEFAULT_LENGTH_W,
   parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                request,
   input  logic [LENGTH_W-1:0] length,
   output logic                data_req,
   input  logic                data_in,
   output logic                data_out,
   output logic                valid,
   output logic                busy,
   output logic                done
`ifdef TX_RUNTIME_SEED_EN
   ,
   input  logic [LFSR_W-1:0]   seed
`endif
);

   localparam logic [LENGTH_W-1:0] LEN_ONE = 1;

   state_t              state_q;
   state_t              state_d;
   logic [LENGTH_W-1:0] length_q;
   logic [LENGTH_W-1:0] count_q;
   logic                data_out_q;
   logic                valid_q;
   logic                last_bit;
   logic                lfsr_fb_bit;
   logic [LFSR_W-1:0]   lfsr_load_value;
   // The register contents are only needed by the receive side.
   logic [LFSR_W-1:0]   lfsr_state_unused;

`ifdef TX_RUNTIME_SEED_EN
   logic [LFSR_W-1:0]   seed_q;
   assign lfsr_load_value = seed_q;
`else
   assign lfsr_load_value = SEED;
`endif

   // length_q is non-zero whenever SCRAMBLING is reached, so the subtraction
   // cannot underflow where it matters; the compare exits before count wraps.
   assign last_bit = (count_q == (length_q - LEN_ONE));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:       if (request) state_d = INIT;
         INIT:       state_d = (length_q == '0) ? FINISH : SCRAMBLING;
         SCRAMBLING: if (last_bit) state_d = FINISH;
         FINISH:     state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         length_q   <= '0;
         count_q    <= '0;
         data_out_q <= 1'b0;
         valid_q    <= 1'b0;
`ifdef TX_RUNTIME_SEED_EN
         seed_q     <= SEED;
`endif
      end else begin
         // One valid cycle per consumed bit, trailing the sample by one edge.
         valid_q <= (state_q == SCRAMBLING);
         case (state_q)
            IDLE: begin
               if (request) begin
                  length_q <= length;
`ifdef TX_RUNTIME_SEED_EN
                  // An all-zero seed would lock the LFSR at zero.
                  seed_q   <= (seed == '0) ? SEED : seed;
`endif
               end
            end
            INIT: begin
               count_q <= '0;
            end
            SCRAMBLING: begin
               data_out_q <= data_in ^ lfsr_fb_bit;
               count_q    <= count_q + LEN_ONE;
            end
            default: ;
         endcase
      end
   end

   scrambler_lfsr #(
      .RESET_SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .reset   (reset),
      .load_i  (state_q == INIT),
      .shift_i (state_q == SCRAMBLING),
      .seed_i  (lfsr_load_value),
      .state_o (lfsr_state_unused),
      .fb_o    (lfsr_fb_bit)
   );

   assign data_req = (state_q == SCRAMBLING);
   assign busy     = (state_q != IDLE);
   assign done     = (state_q == FINISH);
   assign data_out = data_out_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_scrambler_tx.sv
// -----------------------------------------------------------------------------
// tb_scrambler_tx
// Directed bench for scrambler_tx: reset state, 8-bit zero frame against the
// hand-derived keystream 00001110, zero-length frame, request/length changes
// during a frame, mid-frame reset, a 200-bit loopback through a descrambler
// model, and (with TX_RUNTIME_SEED_EN) the zero-seed fallback.
// -----------------------------------------------------------------------------
module tb_scrambler_tx;

   logic        clk = 1'b0;
   logic        reset;
   logic        request;
   logic [11:0] length;
   logic        data_req;
   logic        data_in;
   logic        data_out;
   logic        valid;
   logic        busy;
   logic        done;
`ifdef TX_RUNTIME_SEED_EN
   logic [6:0]  seed;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   scrambler_tx dut (
      .clk      (clk),
      .reset    (reset),
      .request  (request),
      .length   (length),
      .data_req (data_req),
      .data_in  (data_in),
      .data_out (data_out),
      .valid    (valid),
      .busy     (busy),
      .done     (done)
`ifdef TX_RUNTIME_SEED_EN
      ,
      .seed     (seed)
`endif
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full 8-bit all-zero frame: output equals the keystream from seed 7F.
   task automatic run_zero8(input string tag);
      logic [7:0] exp_pat;
      exp_pat = 8'b0000_1110;
      request = 1'b1;
      length  = 12'd8;
      data_in = 1'b0;
      tick();
      request = 1'b0;
      check_val({tag, "_init_busy"}, busy, 1);
      check_val({tag, "_init_req"}, data_req, 0);
      tick();
      check_val({tag, "_scr_req"}, data_req, 1);
      check_val({tag, "_scr_valid"}, valid, 0);
      for (int i = 0; i < 8; i++) begin
         tick();
         check_val($sformatf("%s_valid%0d", tag, i), valid, 1);
         check_val($sformatf("%s_dout%0d", tag, i), data_out, exp_pat[7-i]);
         check_val($sformatf("%s_done%0d", tag, i), done, (i == 7) ? 1 : 0);
      end
      tick();
      check_val({tag, "_end_busy"}, busy, 0);
      check_val({tag, "_end_valid"}, valid, 0);
      check_val({tag, "_end_done"}, done, 0);
   endtask

   initial begin
      logic [199:0] bits;
      logic [6:0]   rx_s;
      logic         rx_fb;
      int           n_in;
      int           n_out;
      int           errs;
      int           vcnt;
      bit           saw_done;

      reset   = 1'b1;
      request = 1'b0;
      length  = '0;
      data_in = 1'b0;
`ifdef TX_RUNTIME_SEED_EN
      seed    = 7'h7F;
`endif
      tick();
      tick();
      reset = 1'b0;
      check_val("rst_busy", busy, 0);
      check_val("rst_valid", valid, 0);
      check_val("rst_dout", data_out, 0);
      check_val("rst_done", done, 0);
      check_val("rst_req", data_req, 0);

      // 1: basic 8-bit frame
      run_zero8("t1");

      // 2: zero-length frame
      request = 1'b1;
      length  = 12'd0;
      tick();
      request = 1'b0;
      check_val("t2_init_req", data_req, 0);
      check_val("t2_init_done", done, 0);
      tick();
      check_val("t2_done", done, 1);
      check_val("t2_req", data_req, 0);
      check_val("t2_valid", valid, 0);
      tick();
      check_val("t2_idle_busy", busy, 0);

      // 3: request and length held/changed during the frame are ignored
      request = 1'b1;
      length  = 12'd4;
      tick();
      length   = 12'd12;
      vcnt     = 0;
      saw_done = 1'b0;
      for (int i = 0; i < 20 && !saw_done; i++) begin
         tick();
         if (valid) vcnt++;
         if (done) begin
            saw_done = 1'b1;
            request  = 1'b0;
         end
      end
      request = 1'b0;
      check_val("t3_saw_done", saw_done, 1);
      check_val("t3_valid_cnt", vcnt, 4);
      tick();
      check_val("t3_idle_busy", busy, 0);
      check_val("t3_idle_valid", valid, 0);

      // 4: reset in the middle of a 16-bit frame
      request = 1'b1;
      length  = 12'd16;
      data_in = 1'b0;
      tick();
      request = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         tick();
         check_val($sformatf("t4_valid%0d", i), valid, 1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("t4_rst_valid", valid, 0);
      check_val("t4_rst_busy", busy, 0);
      check_val("t4_rst_done", done, 0);
      check_val("t4_rst_dout", data_out, 0);
      tick();
      check_val("t4_idle_done", done, 0);
      run_zero8("t4");

      // 5: 200-bit loopback through a descrambler model seeded with 7F
      for (int i = 0; i < 200; i++) bits[i] = 1'($urandom_range(1, 0));
      rx_s    = 7'h7F;
      n_in    = 0;
      n_out   = 0;
      errs    = 0;
      request = 1'b1;
      length  = 12'd200;
      tick();
      request = 1'b0;
      for (int cyc = 0; cyc < 400 && n_out < 200; cyc++) begin
         if (valid) begin
            rx_fb = rx_s[6] ^ rx_s[3];
            if ((data_out ^ rx_fb) !== bits[n_out]) errs++;
            rx_s = {rx_s[5:0], rx_fb};
            n_out++;
         end
         if (data_req) begin
            data_in = bits[n_in];
            n_in++;
         end
         if (n_out < 200) tick();
      end
      check_val("t5_bits_out", n_out, 200);
      check_val("t5_bits_in", n_in, 200);
      check_val("t5_errors", errs, 0);
      check_val("t5_last_done", done, 1);
      data_in = 1'b0;
      tick();
      check_val("t5_idle_busy", busy, 0);

`ifdef TX_RUNTIME_SEED_EN
      // 6: zero seed falls back to the default seed
      seed = 7'h00;
      run_zero8("t6");
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
